// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op codes as decoded from the instruction
//   - HI/LO write-enable codes driven on hilo_muldiv.we
//   - FSM state encoding
//   - number of iterative datapath steps
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] WE_BOTH = 2'b11;
    localparam logic [1:0] WE_HI   = 2'b01;
    localparam logic [1:0] WE_LO   = 2'b00;
    localparam logic [1:0] WE_NONE = 2'b10;

    localparam int CALC_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // MULT/MULTU/DIV/DIVU all have op[2]==0; they use the iterative datapath.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned 32-step shift datapath shared by multiply and divide.
//   clk, rst     : clock, async active-high reset
//   load         : capture operand magnitudes and clear the step counter
//   step         : advance one iteration (ignored once all steps are done)
//   is_div       : sampled with load; selects restoring divide vs shift-add multiply
//   a_mag, b_mag : unsigned operands (multiplicand/multiplier or dividend/divisor)
//   hi, lo       : multiply -> {upper, lower} product; divide -> {remainder, quotient}
//   done         : all CALC_STEPS iterations have been performed
module muldiv_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CNT_W = $clog2(CALC_STEPS) + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CALC_STEPS);

    // m holds the multiplicand or the divisor. For multiply, {hi,lo} starts as
    // {0, multiplier}; for divide as {0, dividend}, so both algorithms shift
    // through the same pair of registers.
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_sh;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    assign done = (cnt_q == CNT_END);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        div_d = div_q;

        // Multiply: conditionally add, then shift the 65-bit {carry,hi,lo} right.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // keep the difference only if it did not go negative.
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = (div_sh >= {1'b0, m_q});

        if (load) begin
            m_d   = is_div ? b_mag : a_mag;
            hi_d  = '0;
            lo_d  = is_div ? a_mag : b_mag;
            cnt_d = '0;
            div_d = is_div;
        end else if (step && !done) begin
            if (div_q) begin
                hi_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: EX-stage multiply/divide unit driving the HI/LO write port.
//   clk, rst       : clock, async active-high reset
//   start, op      : request from decode (sampled in IDLE only)
//   a, b           : rs / rt operands
//   cancel         : pipeline flush; abort without writing
//   busy           : stall request (combinational, asserted in the issue cycle)
//   we             : 11 both, 01 HI, 00 LO, 10 no write; one-cycle pulse
//   hi_out, lo_out : registered HI/LO write data
//   dbg_state      : current FSM state
//
// Handshake: a mul/div request is taken on the edge where state is IDLE,
// start=1, op is arithmetic and cancel=0; busy is high in that cycle and
// through CALC, low in DONE. The write lands as a single cycle with we!=10.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [1:0]       we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic [1:0]       we_q, we_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;  // quotient/product sign
    logic             neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic             dbz_q, dbz_d;          // divisor was zero

    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_load, core_step, core_done;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    assign core_load = (state_q == ST_IDLE) && start && is_arith(op) && !cancel;
    assign core_step = (state_q == ST_CALC);
    assign busy      = (state_q == ST_CALC) || core_load;

    assign prod     = {core_hi, core_lo};
    assign prod_fix = neg_res_q ? -prod : prod;
    // Division by zero leaves the all-ones quotient untouched regardless of signs.
    assign quo_fix  = (neg_res_q && !dbz_q) ? -core_lo : core_lo;
    assign rem_fix  = neg_rem_q ? -core_hi : core_hi;

    assign we        = we_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .step   (core_step),
        .is_div (op[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi     (core_hi),
        .lo     (core_lo),
        .done   (core_done)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = WE_NONE;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (is_arith(op)) begin
                        state_d   = ST_CALC;
                        div_d     = op[1];
                        neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = signed_op && op[1] && a[WIDTH-1];
                        dbz_d     = (b == '0);
                    end else if (op == OP_MTHI) begin
                        state_d = ST_DONE;
                        hi_d    = a;
                        we_d    = WE_HI;
                    end else if (op == OP_MTLO) begin
                        state_d = ST_DONE;
                        lo_d    = a;
                        we_d    = WE_LO;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (core_done) begin
                    state_d = ST_DONE;
                    we_d    = WE_BOTH;
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            we_q      <= WE_NONE;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed vector bench for hilo_muldiv.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [1:0]  we;
    logic [31:0] hi_out, lo_out;
    state_e      dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .we        (we),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE. Issues the op, waits for the
    // write pulse, checks latency/busy/data, and returns at the following
    // negedge (IDLE again) so the next call issues back-to-back.
    task automatic run_op(input int idx, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        logic       arith;
        logic [1:0] exp_we;
        int         cyc;
        int         bcnt;
        logic       seen;
        string      tag;
        tag    = $sformatf("vec%0d", idx);
        arith  = (o[2] == 1'b0);
        exp_we = arith ? WE_BOTH : ((o == OP_MTHI) ? WE_HI : WE_LO);
        start = 1'b1; op = o; a = av; b = bv;
        #1;
        check({tag, " busy_at_issue"}, busy, arith);
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        cyc = 0; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (we != WE_NONE) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt++;
                cyc++;
                @(negedge clk);
            end
        end
        check({tag, " write_seen"}, seen, 1'b1);
        check({tag, " cycles_to_write"}, cyc, arith ? 33 : 0);
        check({tag, " busy_cycles"}, bcnt, arith ? 33 : 0);
        check({tag, " we"}, we, exp_we);
        check({tag, " hi"}, hi_out, ehi);
        check({tag, " lo"}, lo_out, elo);
        check({tag, " busy_in_done"}, busy, 1'b0);
        @(negedge clk);
        check({tag, " we_after"}, we, WE_NONE);
        check({tag, " state_after"}, dbg_state, ST_IDLE);
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000};
        vecs[6]  = '{OP_MTLO,  32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D};
        vecs[7]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        // Reset, then five idle cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d we", i), we, WE_NONE);
            check($sformatf("idle%0d hi", i), hi_out, 32'h0);
            check($sformatf("idle%0d lo", i), lo_out, 32'h0);
            check($sformatf("idle%0d busy", i), busy, 1'b0);
        end

        // Vector table, issued back-to-back.
        for (int i = 0; i < 12; i++)
            run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        // cancel wins over start in IDLE.
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5; cancel = 1'b1;
        #1;
        check("cancel_vs_start busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = 3'b111;
        check("cancel_vs_start state", dbg_state, ST_IDLE);
        check("cancel_vs_start we", we, WE_NONE);

        // DIVU cancelled at CALC step 10.
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        repeat (10) @(negedge clk);
        check("cancel calc_state", dbg_state, ST_CALC);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel state", dbg_state, ST_IDLE);
        check("cancel we", we, WE_NONE);
        check("cancel busy", busy, 1'b0);
        check("cancel hi", hi_out, last_hi);
        check("cancel lo", lo_out, last_lo);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (we != WE_NONE) pulses++;
        end
        check("cancel no_write", pulses, 0);
        check("cancel hi_later", hi_out, last_hi);

        // Same, but reset at step 10: outputs clear asynchronously.
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst hi", hi_out, 32'h0);
        check("rst lo", lo_out, 32'h0);
        check("rst we", we, WE_NONE);
        check("rst busy", busy, 1'b0);
        check("rst state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (we != WE_NONE) pulses++;
        end
        check("rst no_write", pulses, 0);

        // Recovery after reset.
        run_op(12, OP_MULTU, 32'd3, 32'd4, 32'h0, 32'hC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
